epb_slave_ctrl: RTL and testbench

Sequencing controller for the EPB data/control pads. It takes the delayed pad signals (chip select, read/write, byte enables, address, general-purpose address, data-in) into the system clock domain. It turns each PPC access into one single-beat strobe/ack transaction on the internal register bus. It drives the tri-state data-bus output enable and return data, and the EPB ready line back to the PPC. It also supplies a bus timeout so a missing slave can never hang the processor.

---
 rtl/epb_slave_ctrl_if.sv | 30 +++
 rtl/epb_slave_ctrl.sv | 149 ++++++++++++++
 tb/tb_epb_slave_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epb_slave_ctrl_if.sv
// Internal register bus between the EPB slave controller and the register slaves.
// One single-beat transaction per EPB access: the master raises bus_stb with a
// stable address, write data, byte selects and direction, and the slave answers
// with a one-cycle bus_ack, which carries bus_rd_data on a read.
//   bus_addr    29  {epb_addr_gp, epb_addr}
//   bus_wr_data 16  write data
//   bus_sel      2  byte selects, active-high
//   bus_we       1  1 = write
//   bus_stb      1  transaction strobe
//   bus_rd_data 16  read data, valid with bus_ack
//   bus_ack      1  single-cycle acknowledge
interface epb_slave_ctrl_if;
   logic [28:0] bus_addr;
   logic [15:0] bus_wr_data;
   logic [1:0]  bus_sel;
   logic        bus_we;
   logic        bus_stb;
   logic [15:0] bus_rd_data;
   logic        bus_ack;

   modport master (
      output bus_addr, bus_wr_data, bus_sel, bus_we, bus_stb,
      input  bus_rd_data, bus_ack
   );

   modport slave (
      input  bus_addr, bus_wr_data, bus_sel, bus_we, bus_stb,
      output bus_rd_data, bus_ack
   );
endinterface

// File: rtl/epb_slave_ctrl.sv
// EPB slave sequencing controller.
// Brings the PPC EPB pad signals into the clk domain and turns each access
// into exactly one strobe/ack transaction on the internal register bus. It
// drives the pad data/output-enable and the EPB ready line, and aborts a
// transaction that is not acknowledged within TIMEOUT_CYCLES.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   epb_cs_n          chip select (async, synchronized here)
//   epb_r_w_n         1 = read, 0 = write
//   epb_be_n          byte enables, active-low
//   epb_addr          word address
//   epb_addr_gp       general-purpose upper address
//   epb_data_in       data from the pads
//   epb_data_out      registered data to the pads
//   epb_data_oe_n     pad tri-state control, 0 drives
//   epb_rdy           ready to the PPC
//   bus               register bus, master side
//   bus_timeout       one-cycle pulse on abort
//   timeout_count     saturating abort count
module epb_slave_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned RDY_CYCLES     = 2,
   parameter logic [15:0] TIMEOUT_DATA   = 16'hDEAD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    epb_cs_n,
   input  logic                    epb_r_w_n,
   input  logic [1:0]              epb_be_n,
   input  logic [22:0]             epb_addr,
   input  logic [5:0]              epb_addr_gp,
   input  logic [15:0]             epb_data_in,
   output logic [15:0]             epb_data_out,
   output logic                    epb_data_oe_n,
   output logic                    epb_rdy,
   epb_slave_ctrl_if.master        bus,
   output logic                    bus_timeout,
   output logic [15:0]             timeout_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // Terminal value of the wait counter: the counter starts at 0 in the first
   // strobe cycle, so reaching TIMEOUT_CYCLES-1 means stb has been high for
   // exactly TIMEOUT_CYCLES cycles.
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    RDY_N   = 4'(RDY_CYCLES);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STROBE = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   logic          cs_meta;
   logic          cs_s;
   logic [1:0]    state;
   logic [TW-1:0] to_cnt;
   logic [3:0]    rdy_cnt;
   logic          done;

   // Chip select synchronizer; idle (high) out of reset so no access starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_meta <= 1'b1;
         cs_s    <= 1'b1;
      end else begin
         cs_meta <= epb_cs_n;
         cs_s    <= cs_meta;
      end
   end

   // Transaction ends on ack, or on the terminal count; ack has priority so a
   // coincident ack still returns real data.
   assign done = bus.bus_ack || (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         to_cnt          <= '0;
         rdy_cnt         <= '0;
         epb_data_out    <= '0;
         epb_data_oe_n   <= 1'b1;
         epb_rdy         <= 1'b0;
         bus.bus_addr    <= '0;
         bus.bus_wr_data <= '0;
         bus.bus_sel     <= '0;
         bus.bus_we      <= 1'b0;
         bus.bus_stb     <= 1'b0;
         bus_timeout     <= 1'b0;
         timeout_count   <= '0;
      end else begin
         bus_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!cs_s) begin
                  // Pad address/data are stable while cs_n is low.
                  bus.bus_addr    <= {epb_addr_gp, epb_addr};
                  bus.bus_we      <= ~epb_r_w_n;
                  bus.bus_sel     <= ~epb_be_n;
                  bus.bus_wr_data <= epb_data_in;
                  bus.bus_stb     <= 1'b1;
                  to_cnt          <= '0;
                  state           <= S_STROBE;
               end
            end
            S_STROBE: begin
               if (done) begin
                  bus.bus_stb <= 1'b0;
                  if (!bus.bus_we)
                     epb_data_out <= bus.bus_ack ? bus.bus_rd_data : TIMEOUT_DATA;
                  if (!bus.bus_ack) begin
                     bus_timeout <= 1'b1;
                     if (timeout_count != 16'hFFFF)
                        timeout_count <= timeout_count + 16'd1;
                  end
                  // Master gave up: drop the access silently.
                  if (cs_s) begin
                     state <= S_IDLE;
                  end else begin
                     state   <= S_RESP;
                     rdy_cnt <= '0;
                     if (!bus.bus_we)
                        epb_data_oe_n <= 1'b0;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_RESP: begin
               if (rdy_cnt < RDY_N) begin
                  epb_rdy <= 1'b1;
                  rdy_cnt <= rdy_cnt + 4'd1;
               end else begin
                  epb_rdy <= 1'b0;
                  state   <= S_HOLD;
               end
            end
            S_HOLD: begin
               // Wait for cs to go away so one cs_n low period is one strobe.
               if (cs_s) begin
                  epb_data_oe_n <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_epb_slave_ctrl.sv
// Self-checking bench for epb_slave_ctrl: a table of directed accesses, a
// randomized run against a transaction-level reference model, and hand
// sequences for reset-state and reset during a read.
module tb_epb_slave_ctrl;

   localparam int TMO = 16;
   localparam int RDY = 2;
   localparam logic [15:0] TDATA = 16'hDEAD;

   logic        clk;
   logic        rst_n;
   logic        epb_cs_n;
   logic        epb_r_w_n;
   logic [1:0]  epb_be_n;
   logic [22:0] epb_addr;
   logic [5:0]  epb_addr_gp;
   logic [15:0] epb_data_in;
   logic [15:0] epb_data_out;
   logic        epb_data_oe_n;
   logic        epb_rdy;
   logic        bus_timeout;
   logic [15:0] timeout_count;

   epb_slave_ctrl_if bus_if ();

   epb_slave_ctrl #(
      .TIMEOUT_CYCLES (TMO),
      .RDY_CYCLES     (RDY),
      .TIMEOUT_DATA   (TDATA)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .epb_cs_n      (epb_cs_n),
      .epb_r_w_n     (epb_r_w_n),
      .epb_be_n      (epb_be_n),
      .epb_addr      (epb_addr),
      .epb_addr_gp   (epb_addr_gp),
      .epb_data_in   (epb_data_in),
      .epb_data_out  (epb_data_out),
      .epb_data_oe_n (epb_data_oe_n),
      .epb_rdy       (epb_rdy),
      .bus           (bus_if.master),
      .bus_timeout   (bus_timeout),
      .timeout_count (timeout_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   typedef struct {
      bit          rw;
      logic [22:0] addr;
      logic [5:0]  gp;
      logic [1:0]  be;
      logic [15:0] din;
      int          wt;      // ack on strobe cycle wt+1; -1 = never
      logic [15:0] rdata;
      bit          abandon;
      int          extra;   // cycles cs_n stays low after rdy falls
      logic [28:0] e_addr;
      bit          e_we;
      logic [1:0]  e_sel;
      int          e_stb;
      bit          e_tmo;
      int          e_rdy;
      bit          e_oe;
      logic [15:0] e_dout;
      logic [15:0] e_tcnt;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] m_dout;
   logic [15:0] m_tcnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit rw, logic [22:0] a, logic [5:0] gp, logic [1:0] be,
                               logic [15:0] din, int wt, logic [15:0] rd, bit ab, int ex,
                               logic [28:0] ea, bit ewe, logic [1:0] esel, int es, bit et,
                               int er, bit eo, logic [15:0] ed, logic [15:0] ec);
      vec_t v;
      v.rw = rw; v.addr = a; v.gp = gp; v.be = be; v.din = din; v.wt = wt;
      v.rdata = rd; v.abandon = ab; v.extra = ex;
      v.e_addr = ea; v.e_we = ewe; v.e_sel = esel; v.e_stb = es; v.e_tmo = et;
      v.e_rdy = er; v.e_oe = eo; v.e_dout = ed; v.e_tcnt = ec;
      return v;
   endfunction

   // Transaction-level reference: what one access should look like from outside.
   function automatic vec_t model(vec_t v);
      bit acked;
      vec_t r;
      r = v;
      acked    = (v.wt >= 0) && (v.wt < TMO);
      r.e_addr = {v.gp, v.addr};
      r.e_we   = ~v.rw;
      r.e_sel  = ~v.be;
      r.e_stb  = acked ? v.wt + 1 : TMO;
      r.e_tmo  = !acked;
      if (!acked && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
      if (v.rw) m_dout = acked ? v.rdata : TDATA;
      r.e_tcnt = m_tcnt;
      r.e_dout = m_dout;
      r.e_rdy  = v.abandon ? 0 : RDY;
      r.e_oe   = v.rw && !v.abandon;
      return r;
   endfunction

   function automatic vec_t rnd();
      vec_t v;
      int sel;
      v = mk(1'($urandom), 23'($urandom), 6'($urandom), 2'($urandom), 16'($urandom),
             0, 16'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(0, 4),
             '0, 0, '0, 0, 0, 0, 0, '0, '0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      v.wt = -1;
      else if (sel == 1) v.wt = TMO - 1;
      else if (sel == 2) v.wt = TMO + 3;
      else               v.wt = $urandom_range(0, 8);
      // Abandon must land while the strobe is still waiting.
      if (v.abandon && v.wt >= 0 && v.wt < 4) v.wt = $urandom_range(4, 12);
      return v;
   endfunction

   // Runs one EPB access with a behavioural PPC master and register slave,
   // then compares everything observed with the expected fields of v.
   task automatic run_access(input vec_t v, input bit noise);
      int e, stb_first, stb_cyc, stb_rises, tmo_n, tmo_first, rdy_n, rdy_first;
      int oe_first, oe_rise, rel_e, h;
      bit prev_stb, prev_rdy, released, rdy_fell, oe_low, done, to;
      logic [28:0] cap_addr;
      logic        cap_we;
      logic [1:0]  cap_sel;
      logic [15:0] cap_wd;
      e = 0; stb_first = -1; stb_cyc = 0; stb_rises = 0; tmo_n = 0; tmo_first = -1;
      rdy_n = 0; rdy_first = -1; oe_first = -1; oe_rise = -1; rel_e = -1; h = 0;
      prev_stb = 0; prev_rdy = 0; released = 0; rdy_fell = 0; oe_low = 0; done = 0; to = 0;
      cap_addr = 'x; cap_we = 1'bx; cap_sel = 'x; cap_wd = 'x;
      epb_r_w_n = v.rw; epb_addr = v.addr; epb_addr_gp = v.gp; epb_be_n = v.be;
      epb_data_in = v.din; epb_cs_n = 1'b0;
      while (!done) begin
         @(posedge clk); #1;
         if (bus_if.bus_stb) begin
            stb_cyc++;
            if (!prev_stb) begin
               stb_rises++;
               if (stb_first < 0) begin
                  stb_first = e;
                  cap_addr = bus_if.bus_addr; cap_we = bus_if.bus_we;
                  cap_sel = bus_if.bus_sel; cap_wd = bus_if.bus_wr_data;
               end
            end
         end
         if (bus_timeout) begin tmo_n++; if (tmo_first < 0) tmo_first = e; end
         if (epb_rdy) begin rdy_n++; if (rdy_first < 0) rdy_first = e; end
         if (!epb_data_oe_n) begin
            oe_low = 1; if (oe_first < 0) oe_first = e;
         end else if (released && oe_low && oe_rise < 0) oe_rise = e;
         // Slave: answer the strobe; optional stray acks while idle.
         if (bus_if.bus_stb) begin
            bus_if.bus_ack = (v.wt >= 0) && (stb_cyc == v.wt + 1);
            bus_if.bus_rd_data = bus_if.bus_ack ? v.rdata : 16'($urandom);
         end else begin
            bus_if.bus_ack = noise ? 1'($urandom) : 1'b0;
            bus_if.bus_rd_data = 16'($urandom);
         end
         // Master: abandon mid-strobe, or release cs_n after rdy.
         if (prev_rdy && !epb_rdy) rdy_fell = 1;
         if (!released) begin
            if (v.abandon && stb_cyc == 2) begin
               released = 1; rel_e = e; epb_cs_n = 1'b1;
            end else if (!v.abandon && rdy_fell) begin
               if (h == v.extra) begin released = 1; rel_e = e; epb_cs_n = 1'b1; end
               else h++;
            end
         end
         if (released && !bus_if.bus_stb && e >= rel_e + 3) done = 1;
         if (e >= 400) begin to = 1; done = 1; end
         prev_stb = bus_if.bus_stb; prev_rdy = epb_rdy; e++;
      end
      bus_if.bus_ack = 1'b0;
      chk("no_hang", 64'(to), 64'(0));
      chk("stb_latency", 64'(stb_first), 64'(2));
      chk("stb_cycles", 64'(stb_cyc), 64'(v.e_stb));
      chk("stb_count", 64'(stb_rises), 64'(1));
      chk("bus_addr", 64'(cap_addr), 64'(v.e_addr));
      chk("bus_we", 64'(cap_we), 64'(v.e_we));
      chk("bus_sel", 64'(cap_sel), 64'(v.e_sel));
      chk("bus_wr_data", 64'(cap_wd), 64'(v.din));
      chk("timeout_pulses", 64'(tmo_n), 64'(v.e_tmo));
      if (v.e_tmo) chk("timeout_edge", 64'(tmo_first), 64'(2 + TMO));
      chk("timeout_count", 64'(timeout_count), 64'(v.e_tcnt));
      chk("rdy_cycles", 64'(rdy_n), 64'(v.e_rdy));
      if (v.e_rdy > 0) chk("rdy_latency", 64'(rdy_first), 64'(3 + v.e_stb));
      chk("oe_low", 64'(oe_low), 64'(v.e_oe));
      if (v.e_oe) begin
         chk("oe_fall", 64'(oe_first), 64'(2 + v.e_stb));
         chk("oe_release", 64'(oe_rise), 64'(rel_e + 3));
      end
      chk("data_out", 64'(epb_data_out), 64'(v.e_dout));
   endtask

   vec_t tbl[8];

   initial begin
      vec_t v;
      bit seen, fell;
      tbl[0] = mk(1, 23'h000010, 6'h01, 2'b00, 16'h0000,  0, 16'hA5C3, 0, 0,
                  29'h00800010, 0, 2'b11,  1, 0, 2, 1, 16'hA5C3, 16'd0);
      tbl[1] = mk(0, 23'h7FFFFF, 6'h3F, 2'b10, 16'h1234,  7, 16'h0000, 0, 2,
                  29'h1FFFFFFF, 1, 2'b01,  8, 0, 2, 0, 16'hA5C3, 16'd0);
      tbl[2] = mk(1, 23'h2AAAAA, 6'h15, 2'b01, 16'h0000, -1, 16'h0000, 0, 0,
                  29'h0AAAAAAA, 0, 2'b10, 16, 1, 2, 1, 16'hDEAD, 16'd1);
      tbl[3] = mk(1, 23'h000100, 6'h00, 2'b00, 16'h0000, 10, 16'h5A5A, 1, 0,
                  29'h00000100, 0, 2'b11, 11, 0, 0, 0, 16'h5A5A, 16'd1);
      tbl[4] = mk(1, 23'h000004, 6'h02, 2'b00, 16'h0000,  0, 16'hBEEF, 0, 3,
                  29'h01000004, 0, 2'b11,  1, 0, 2, 1, 16'hBEEF, 16'd1);
      tbl[5] = mk(1, 23'h000008, 6'h02, 2'b00, 16'h0000, 15, 16'h1357, 0, 0,
                  29'h01000008, 0, 2'b11, 16, 0, 2, 1, 16'h1357, 16'd1);
      tbl[6] = mk(0, 23'h000000, 6'h00, 2'b01, 16'hFFFF, -1, 16'h0000, 0, 1,
                  29'h00000000, 1, 2'b10, 16, 1, 2, 0, 16'h1357, 16'd2);
      tbl[7] = mk(0, 23'h00000C, 6'h00, 2'b11, 16'h0F0F, -1, 16'h0000, 1, 0,
                  29'h0000000C, 1, 2'b00, 16, 1, 0, 0, 16'h1357, 16'd3);

      rst_n = 1'b0; epb_cs_n = 1'b1; epb_r_w_n = 1'b1; epb_be_n = 2'b11;
      epb_addr = '0; epb_addr_gp = '0; epb_data_in = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rd_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_out", 64'(epb_data_out), 64'(0));
      chk("rst_oe_n", 64'(epb_data_oe_n), 64'(1));
      chk("rst_rdy", 64'(epb_rdy), 64'(0));
      chk("rst_bus_addr", 64'(bus_if.bus_addr), 64'(0));
      chk("rst_bus_wr_data", 64'(bus_if.bus_wr_data), 64'(0));
      chk("rst_bus_sel", 64'(bus_if.bus_sel), 64'(0));
      chk("rst_bus_we", 64'(bus_if.bus_we), 64'(0));
      chk("rst_bus_stb", 64'(bus_if.bus_stb), 64'(0));
      chk("rst_timeout", 64'(bus_timeout), 64'(0));
      chk("rst_timeout_count", 64'(timeout_count), 64'(0));
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_no_stb", 64'(bus_if.bus_stb), 64'(0));

      for (int i = 0; i < 8; i++) run_access(tbl[i], 1'b0);
      m_dout = 16'h1357;
      m_tcnt = 16'd3;

      for (int i = 0; i < 30; i++) begin
         v = model(rnd());
         run_access(v, 1'b1);
      end

      // Reset while a read holds the pad bus.
      epb_r_w_n = 1'b1; epb_addr = 23'h000020; epb_addr_gp = 6'h00; epb_be_n = 2'b00;
      epb_cs_n = 1'b0; seen = 0; fell = 0;
      for (int c = 0; c < 40 && !fell; c++) begin
         @(posedge clk); #1;
         if (epb_rdy) seen = 1;
         else if (seen) fell = 1;
         bus_if.bus_ack = bus_if.bus_stb;
         bus_if.bus_rd_data = 16'hC0DE;
      end
      bus_if.bus_ack = 1'b0;
      chk("hold_reached", 64'(fell), 64'(1));
      chk("hold_oe_n", 64'(epb_data_oe_n), 64'(0));
      chk("hold_data_out", 64'(epb_data_out), 64'(16'hC0DE));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_oe_n", 64'(epb_data_oe_n), 64'(1));
      chk("arst_rdy", 64'(epb_rdy), 64'(0));
      chk("arst_stb", 64'(bus_if.bus_stb), 64'(0));
      chk("arst_data_out", 64'(epb_data_out), 64'(0));
      chk("arst_bus_addr", 64'(bus_if.bus_addr), 64'(0));
      chk("arst_timeout_count", 64'(timeout_count), 64'(0));
      epb_cs_n = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      m_dout = 16'h0000;
      m_tcnt = 16'd0;
      @(posedge clk); #1;
      v = model(mk(1, 23'h000040, 6'h07, 2'b00, 16'h0000, 2, 16'h4321, 0, 0,
                   '0, 0, '0, 0, 0, 0, 0, '0, '0));
      run_access(v, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
